sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Two-client request arbiter placed directly upstream of the byte-wide sdram controller.
//  It converts per-client req/ack handshakes into the controller's level-sensitive
//  address/we/data inputs and its o_ready status. Port 0 is video fetch; port 1 is CPU
//  load/store. Clients are served one at a time with round-robin fairness.
// PARAMETERS
//  GUARD    2      cycles o_ready is ignored after new outputs are driven (min 2: controller samples, then drops ready)
//  TIMEOUT  255    max cycles in WAIT before the transaction is aborted with err
//  RR       1      1 = round-robin between ports; 0 = port 0 always wins ties
// PORTS
//  clock_100_mhz  in   1   sole clock, same clock as the sdram controller
//  reset          in   1   synchronous, active-high
//  p0_req         in   1   port 0 request; held high until p0_ack
//  p0_we          in   1   port 0 write (1) / read (0)
//  p0_addr        in   26  port 0 byte address
//  p0_wdata       in   8   port 0 write data
//  p0_rdata       out  8   port 0 read data, valid when p0_ack=1
//  p0_ack         out  1   one-cycle completion pulse
//  p0_err         out  1   valid with p0_ack; 1 = timed out
//  p1_*           --   --  identical set for port 1
//  sd_address     out  26  to controller i_address
//  sd_we          out  1   to controller i_we
//  sd_data        out  8   to controller i_data
//  sd_rdata       in   8   from controller o_data
//  sd_ready       in   1   from controller o_ready
// BEHAVIOUR
//  Reset: state=IDLE; sd_address=0, sd_we=0, sd_data=0, pX_rdata=0, pX_ack=0, pX_err=0, last_grant=1.
//  All outputs are registered. The controller sees changed inputs one edge after we drive them.
//  FSM states:
//   IDLE  - grant only when sd_ready=1 and some req=1. This covers the controller's init
//           period and any op still in flight after reset. With both requests high: RR=1 picks
//           the port != last_grant; RR=0 picks port 0. On grant, latch port addr/we/wdata into
//           sd_*, record grant, load guard=GUARD-1, go to ISSUE.
//   ISSUE - decrement guard and ignore sd_ready; go to WAIT when guard hits 0.
//   WAIT  - count tmo. On sd_ready=1, capture sd_rdata into the granted pX_rdata (reads
//           only; writes leave rdata unchanged) and go to DONE. On tmo=TIMEOUT, set
//           pX_rdata=8'hFF and err=1, then go to DONE.
//   DONE  - pX_ack=1 for exactly this cycle (err alongside); sd_we<=0; return to IDLE.
//  Latency: grant edge to ack is GUARD + controller service time + 1 cycles. A repeat read of
//   the last address is answered from controller state: sd_ready never drops, so ack
//   arrives GUARD+2 cycles after grant. A repeat write of identical data behaves the same.
//  sd_address/sd_data hold their last values in IDLE; only sd_we returns to 0. This keeps
//   the controller's change detector quiet between transactions.
//  A req still high in the cycle after ack is a new request. Clients must drop req on ack
//   unless they want another access.
//  Changing pX_addr/we/wdata while req=1 and before ack is illegal. Values are latched at grant.
//  A req rising while the other port is served waits. No request is lost, and a port waits
//   at most one foreign transaction (RR=1).
//  Reset mid-transaction: immediate return to IDLE with reset values and no ack issued. The
//   IDLE sd_ready gate prevents a grant until the controller finishes.
//  tmo is 8 bits wide for the default; width = clog2(TIMEOUT+1). Counters saturate, never wrap.
// STRUCTURE
//  Package sdram_arb_pkg: FSM state encoding (IDLE, ISSUE, WAIT, DONE), GUARD_MIN=2,
//   ERR_RDATA=8'hFF.
//  Sub-module sdram_arb_pick: combinational 2-way pick (req0, req1, last_grant, RR) -> grant
//   index and valid. Everything else stays in one module.
// TESTING
//  Bench uses a behavioural controller model: drops ready 1 edge after an input change, raises it N cycles later.
//  1 p1 read 0x0000123, model rdata 0x5A, N=10 -> p1_ack once, p1_rdata=0x5A, p1_err=0, sd_we=0 after.
//  2 p0 and p1 req same cycle, RR=1, last_grant=1 -> p0 served first, then p1. RR=0 with
//    p0 held high continuously -> p1 starved; check RR=1 instead alternates 0,1,0,1.
//  3 p1 write 0x0000010 <- 0xA5, then p1 read 0x0000010 (no change) -> second ack GUARD+2
//    cycles after grant, rdata=0xA5.
//  4 Model never raises ready, TIMEOUT=255 -> ack exactly 255 WAIT cycles after entry, err=1, rdata=0xFF.
//  5 Reset asserted 3 cycles into WAIT while model ready=0 -> no ack. After reset, p0 req is
//    granted only once ready=1.
//  6 sd_ready=0 at start (controller init) with p0 req high for 500 cycles -> no grant until
//    ready=1, then normal ack.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and constants for the
// sdram request arbiter (no ports).
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   // The controller needs one edge to sample and one to drop o_ready.
   localparam int GUARD_MIN = 2;

   localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational two-way request pick.
// Ports: req0/req1 requests, last_grant, -> grant index, valid.
module sdram_arb_pick #(
   parameter int RR = 1
) (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
      grant = 1'b0;
      if (req0 && req1) begin
         // Tie: alternate away from the last winner, or fixed port 0.
         grant = (RR != 0) ? ~last_grant : 1'b0;
      end else begin
         grant = req1;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client req/ack front end for the byte-wide sdram
// controller. Ports: clock_100_mhz, reset; p0_*/p1_* client side
// (req/we/addr/wdata in, rdata/ack/err out); sd_* controller side.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 255,
   parameter int RR      = 1
) (
   input  logic        clock_100_mhz,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [25:0] p0_addr,
   input  logic [7:0]  p0_wdata,
   output logic [7:0]  p0_rdata,
   output logic        p0_ack,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [25:0] p1_addr,
   input  logic [7:0]  p1_wdata,
   output logic [7:0]  p1_rdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [25:0] sd_address,
   output logic        sd_we,
   output logic [7:0]  sd_data,
   input  logic [7:0]  sd_rdata,
   input  logic        sd_ready
);

   localparam int GUARD_EFF = (GUARD < GUARD_MIN) ? GUARD_MIN : GUARD;
   localparam int GW = $clog2(GUARD_EFF);
   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_t    state;
   arb_state_t    state_n;
   logic [GW-1:0] guard;
   logic [TW-1:0] tmo;
   logic          last_grant;
   logic          pick_grant;
   logic          pick_valid;
   logic          grant_now;
   logic          rd_ok;
   logic          timed_out;
   logic          tmo_last;

   sdram_arb_pick #(.RR(RR)) u_pick (
      .req0       (p0_req),
      .req1       (p1_req),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .valid      (pick_valid)
   );

   // tmo counts completed WAIT cycles; the TIMEOUT-th one aborts.
   assign tmo_last = (tmo == TW'(TIMEOUT - 1));

   always_comb begin
      state_n   = state;
      grant_now = 1'b0;
      rd_ok     = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: begin
            // sd_ready gate also covers controller init and ops
            // left in flight by a reset.
            if (sd_ready && pick_valid) begin
               grant_now = 1'b1;
               state_n   = ISSUE;
            end
         end
         ISSUE: begin
            if (guard == '0) state_n = WAIT;
         end
         WAIT: begin
            if (sd_ready) begin
               rd_ok   = 1'b1;
               state_n = DONE;
            end else if (tmo_last) begin
               timed_out = 1'b1;
               state_n   = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock_100_mhz) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clock_100_mhz) begin
      if (reset) begin
         sd_address <= '0;
         sd_we      <= 1'b0;
         sd_data    <= '0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         p0_err     <= 1'b0;
         p1_err     <= 1'b0;
         last_grant <= 1'b1;
         guard      <= '0;
         tmo        <= '0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         p0_err <= 1'b0;
         p1_err <= 1'b0;
         if (grant_now) begin
            last_grant <= pick_grant;
            sd_address <= pick_grant ? p1_addr : p0_addr;
            sd_we      <= pick_grant ? p1_we : p0_we;
            sd_data    <= pick_grant ? p1_wdata : p0_wdata;
            guard      <= GW'(GUARD_EFF - 1);
         end
         if (state == ISSUE) begin
            tmo <= '0;
            if (guard != '0) guard <= guard - 1'b1;
         end
         if (state == WAIT && tmo != '1) tmo <= tmo + 1'b1;
         // ack is raised on entry to DONE so it is high for DONE only.
         if (rd_ok || timed_out) begin
            if (last_grant) begin
               p1_ack <= 1'b1;
               p1_err <= timed_out;
            end else begin
               p0_ack <= 1'b1;
               p0_err <= timed_out;
            end
         end
         if (rd_ok && !sd_we) begin
            if (last_grant) p1_rdata <= sd_rdata;
            else            p0_rdata <= sd_rdata;
         end
         if (timed_out) begin
            if (last_grant) p1_rdata <= ERR_RDATA;
            else            p0_rdata <= ERR_RDATA;
         end
         // Address/data hold so the controller sees no change in IDLE.
         if (state == DONE) sd_we <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed + random checks of sdram_arbiter against a
// behavioural sdram controller and a reference memory.
module tb_sdram_arbiter;

   localparam int GUARD   = 2;
   localparam int TIMEOUT = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [25:0] p0_addr = '0;
   logic [7:0]  p0_wdata = '0;
   logic [7:0]  p0_rdata;
   logic        p0_ack, p0_err;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [25:0] p1_addr = '0;
   logic [7:0]  p1_wdata = '0;
   logic [7:0]  p1_rdata;
   logic        p1_ack, p1_err;
   logic [25:0] sd_address;
   logic        sd_we;
   logic [7:0]  sd_data;
   logic [7:0]  sd_rdata = '0;
   logic        sd_ready = 1'b0;

   logic        f0_req = 1'b0, f1_req = 1'b0;
   logic [7:0]  f0_rdata, f1_rdata;
   logic        f0_ack, f1_ack, f0_err, f1_err;
   logic [25:0] f_address;
   logic        f_we;
   logic [7:0]  f_data;

   sdram_arbiter #(.GUARD(GUARD), .TIMEOUT(TIMEOUT), .RR(1)) dut (
      .clock_100_mhz(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
      .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
      .p1_err(p1_err),
      .sd_address(sd_address), .sd_we(sd_we), .sd_data(sd_data),
      .sd_rdata(sd_rdata), .sd_ready(sd_ready)
   );

   sdram_arbiter #(.GUARD(GUARD), .TIMEOUT(TIMEOUT), .RR(0)) dut_f (
      .clock_100_mhz(clk), .reset(reset),
      .p0_req(f0_req), .p0_we(1'b0), .p0_addr(26'h11),
      .p0_wdata(8'h00), .p0_rdata(f0_rdata), .p0_ack(f0_ack),
      .p0_err(f0_err),
      .p1_req(f1_req), .p1_we(1'b0), .p1_addr(26'h22),
      .p1_wdata(8'h00), .p1_rdata(f1_rdata), .p1_ack(f1_ack),
      .p1_err(f1_err),
      .sd_address(f_address), .sd_we(f_we), .sd_data(f_data),
      .sd_rdata(8'h3C), .sd_ready(1'b1)
   );

   // Controller model: any input change drops ready one edge later,
   // ready returns m_n cycles after that; m_hold pins ready low.
   logic [7:0]  cmem [0:4095];
   logic [25:0] m_addr = '0;
   logic        m_we = 1'b0;
   logic [7:0]  m_data = '0;
   int          m_cnt = 5;
   int          m_n = 10;
   bit          m_busy = 1'b1;
   bit          m_hold = 1'b1;

   always @(posedge clk) begin
      if (sd_address != m_addr || sd_we != m_we || sd_data != m_data) begin
         m_addr   <= sd_address;
         m_we     <= sd_we;
         m_data   <= sd_data;
         m_busy   <= 1'b1;
         m_cnt    <= m_n;
         sd_ready <= 1'b0;
      end else if (m_hold) begin
         sd_ready <= 1'b0;
      end else if (m_busy) begin
         if (m_cnt <= 1) begin
            m_busy   <= 1'b0;
            sd_ready <= 1'b1;
            if (m_we) begin
               cmem[m_addr[11:0]] <= m_data;
               sd_rdata <= m_data;
            end else begin
               sd_rdata <= cmem[m_addr[11:0]];
            end
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   logic [7:0]  rm [0:4095];
   logic [7:0]  exp_rd [0:1];
   logic [25:0] trk_addr = '0;
   logic [7:0]  trk_data = '0;
   int          trk_port = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      int k;
      k = 0;
      repeat (3) @(posedge clk);
      #1;
      while (!sd_ready && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("ready_before_req", 32'(sd_ready), 1);
   endtask

   task automatic xfer(input int port, input logic we,
                       input logic [25:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd,
                       output logic er);
      bit got;
      got = 1'b0;
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      if (port == 0) begin
         p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
      end else begin
         p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
      end
      for (int i = 0; i < 2000 && !got; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (port == 0 && p0_ack) begin
            got = 1'b1; rd = p0_rdata; er = p0_err; p0_req = 1'b0;
         end
         if (port == 1 && p1_ack) begin
            got = 1'b1; rd = p1_rdata; er = p1_err; p1_req = 1'b1 & 1'b0;
         end
      end
      chk("ack_arrived", 32'(got), 1);
      p0_req = 1'b0;
      p1_req = 1'b0;
      trk_addr = a;
      trk_data = d;
      trk_port = port;
   endtask

   initial begin
      int         lat, cnt0, cnt1, nack;
      logic [7:0] rd, rd0, rd1;
      logic       er;
      bit         bad, got, p1_seen;
      int         ord [0:3];

      for (int i = 0; i < 4096; i++) begin
         rm[i]   = 8'(i * 7 + 3);
         cmem[i] = rm[i];
      end
      rm[12'h123]   = 8'h5A;
      cmem[12'h123] = 8'h5A;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sd_address", sd_address, 0);
      chk("reset_sd_we_data", {sd_we, sd_data}, 0);
      chk("reset_p0_outs", {p0_rdata, p0_ack, p0_err}, 0);
      chk("reset_p1_outs", {p1_rdata, p1_ack, p1_err}, 0);
      reset = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;

      // Controller still initialising: no grant while ready is low
      p0_addr = 26'h55; p0_we = 1'b0; p0_wdata = '0; p0_req = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (sd_address != 0 || p0_ack || p1_ack) bad = 1'b1;
      end
      chk("init_no_grant", 32'(bad), 0);
      m_hold = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(posedge clk);
         #1;
         if (p0_ack) begin
            got = 1'b1; rd = p0_rdata; p0_req = 1'b0;
         end
      end
      chk("init_ack", 32'(got), 1);
      chk("init_rdata", rd, rm[12'h55]);
      p0_req = 1'b0;
      exp_rd[0] = rm[12'h55];

      // p1 read, N=10
      settle();
      m_n = 10;
      xfer(1, 1'b0, 26'h123, 8'h00, lat, rd, er);
      chk("p1_read_lat", lat, GUARD + 10 + 1);
      chk("p1_read_rdata", rd, 8'h5A);
      chk("p1_read_err", 32'(er), 0);
      @(posedge clk);
      #1;
      chk("p1_read_we_after", 32'(sd_we), 0);
      exp_rd[1] = 8'h5A;

      // Write then repeat read of the same address
      settle();
      xfer(1, 1'b1, 26'h10, 8'hA5, lat, rd, er);
      chk("write_lat", lat, GUARD + 10 + 1);
      chk("write_rdata_kept", rd, exp_rd[1]);
      chk("write_err", 32'(er), 0);
      rm[12'h010] = 8'hA5;
      settle();
      xfer(1, 1'b0, 26'h10, 8'hA5, lat, rd, er);
      chk("repeat_read_lat", lat, GUARD + 2);
      chk("repeat_read_rdata", rd, 8'hA5);
      exp_rd[1] = 8'hA5;

      // Simultaneous requests, last grant was p1
      settle();
      m_n = 4;
      p0_addr = 26'h101; p0_we = 1'b0; p0_wdata = '0;
      p1_addr = 26'h202; p1_we = 1'b0; p1_wdata = '0;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int i = 0; i < 4; i++) ord[i] = 9;
      nack = 0;
      rd0 = '0;
      rd1 = '0;
      for (int i = 0; i < 500 && nack < 2; i++) begin
         @(posedge clk);
         #1;
         if (p0_ack) begin ord[nack] = 0; nack++; rd0 = p0_rdata; p0_req = 1'b0; end
         if (p1_ack) begin ord[nack] = 1; nack++; rd1 = p1_rdata; p1_req = 1'b0; end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      chk("tie_first", ord[0], 0);
      chk("tie_second", ord[1], 1);
      chk("tie_p0_rdata", rd0, rm[12'h101]);
      chk("tie_p1_rdata", rd1, rm[12'h202]);

      // Both held high: strict alternation
      settle();
      for (int i = 0; i < 4; i++) ord[i] = 9;
      nack = 0;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int i = 0; i < 1000 && nack < 4; i++) begin
         @(posedge clk);
         #1;
         if (p0_ack && nack < 4) begin ord[nack] = 0; nack++; end
         if (p1_ack && nack < 4) begin ord[nack] = 1; nack++; end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      chk("alt_order", {ord[0][7:0], ord[1][7:0], ord[2][7:0], ord[3][7:0]},
          32'h00010001);
      exp_rd[0] = rm[12'h101];
      exp_rd[1] = rm[12'h202];

      // Fixed priority instance: p0 held high starves p1
      f0_req = 1'b1; f1_req = 1'b1;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (f0_ack) cnt0++;
         if (f1_ack) cnt1++;
      end
      f0_req = 1'b0; f1_req = 1'b0;
      chk("fixed_p1_starved", cnt1, 0);
      chk("fixed_p0_count", cnt0, 12);
      chk("fixed_p0_rdata", f0_rdata, 8'h3C);

      // Timeout
      settle();
      m_hold = 1'b1;
      xfer(0, 1'b0, 26'h44, 8'h00, lat, rd, er);
      chk("timeout_lat", lat, 1 + GUARD + TIMEOUT);
      chk("timeout_err", 32'(er), 1);
      chk("timeout_rdata", rd, 8'hFF);
      m_hold = 1'b0;

      // Reset while waiting on the controller
      settle();
      m_n = 40;
      p1_addr = 26'h300; p1_we = 1'b0; p1_wdata = '0; p1_req = 1'b1;
      p1_seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (p1_ack) p1_seen = 1'b1;
      end
      reset = 1'b1;
      p1_req = 1'b0;
      p0_addr = 26'h777; p0_we = 1'b0; p0_wdata = '0; p0_req = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset_addr", sd_address, 0);
      bad = 1'b0;
      for (int i = 0; i < 300 && !sd_ready; i++) begin
         if (sd_address != 0 || p0_ack || p1_ack) bad = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("midreset_no_grant", 32'(bad), 0);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(posedge clk);
         #1;
         if (p1_ack) p1_seen = 1'b1;
         if (p0_ack) begin got = 1'b1; rd = p0_rdata; p0_req = 1'b0; end
      end
      p0_req = 1'b0;
      chk("midreset_p0_ack", 32'(got), 1);
      chk("midreset_p0_rdata", rd, rm[12'h777]);
      chk("midreset_no_p1_ack", 32'(p1_seen), 0);
      exp_rd[0] = rm[12'h777];
      exp_rd[1] = '0;
      trk_addr = 26'h777;
      trk_data = '0;
      trk_port = 0;

      // Random traffic against the reference memory
      for (int it = 0; it < 40; it++) begin
         int          port, n, exp_lat;
         logic        we;
         logic [25:0] a;
         logic [7:0]  d, exp_v;
         bit          chg;
         n = $urandom_range(12, 1);
         if ($urandom_range(3) == 0) begin
            port = trk_port; a = trk_addr; d = trk_data; we = 1'b0;
         end else begin
            port = $urandom_range(1);
            we   = 1'($urandom_range(1));
            a    = (port == 1 ? 26'h200 : 26'h100) + 26'($urandom_range(15));
            d    = 8'($urandom);
         end
         chg = we || (a != trk_addr) || (d != trk_data);
         exp_lat = chg ? GUARD + n + 1 : GUARD + 2;
         exp_v = we ? exp_rd[port] : rm[a[11:0]];
         settle();
         m_n = n;
         xfer(port, we, a, d, lat, rd, er);
         chk("rand_lat", lat, exp_lat);
         chk("rand_rdata", rd, exp_v);
         chk("rand_err", 32'(er), 0);
         if (we) rm[a[11:0]] = d;
         else    exp_rd[port] = exp_v;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
